// File: rtl/led_fader_pkg.sv
// led_fader_pkg: shared types and default constants for the LED fader.
//   state_e       - envelope FSM state, encoded 0..3 as seen on state_o
//   DefPwmBits    - default PWM counter / duty width
//   DefStep       - default duty step per tick
//   DefHoldTicks  - default ticks spent in each hold state
//   NumLeds       - number of LED channels driven
package led_fader_pkg;

  typedef enum logic [1:0] {
    RampUp   = 2'd0,
    HoldHi   = 2'd1,
    RampDown = 2'd2,
    HoldLo   = 2'd3
  } state_e;

  localparam int unsigned DefPwmBits   = 8;
  localparam int unsigned DefStep      = 8;
  localparam int unsigned DefHoldTicks = 4;
  localparam int unsigned NumLeds      = 6;

endpackage

// File: rtl/led_fader_pwm_gen.sv
// pwm_gen: free-running PWM counter, period-boundary latching of duty and
// LED pattern, and the registered active-low LED compare.
//   clk       - clock, all state on rising edge
//   rst_n     - asynchronous active-low reset
//   enable_i  - 0 forces all LEDs off (high)
//   duty_i    - requested duty, sampled only at the period boundary
//   pattern_i - LED select, sampled only at the period boundary
//   led_o     - registered active-low LED drive (0 = lit)
module pwm_gen
  import led_fader_pkg::*;
#(
  parameter int unsigned PWM_BITS = DefPwmBits
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic [PWM_BITS-1:0] duty_i,
  input  logic [NumLeds-1:0]  pattern_i,
  output logic [NumLeds-1:0]  led_o
);

  localparam logic [PWM_BITS-1:0] DutyMax = '1;

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] active_duty_q;
  logic [NumLeds-1:0]  active_pat_q;
  logic [NumLeds-1:0]  led_q, led_d;
  logic                boundary;
  logic                lit;

  assign boundary = (pwm_cnt_q == DutyMax);

  // Duty DUTY_MAX lights for counts 0..DUTY_MAX-1, i.e. all but one cycle.
  assign lit   = enable_i && (pwm_cnt_q < active_duty_q);
  assign led_d = ~(active_pat_q & {NumLeds{lit}});
  assign led_o = led_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q     <= '0;
      active_duty_q <= '0;
      active_pat_q  <= '0;
      led_q         <= '1;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      // Latching only here keeps every period whole: no mid-period glitch.
      if (boundary) begin
        active_duty_q <= duty_i;
        active_pat_q  <= pattern_i;
      end
      led_q <= led_d;
    end
  end

endmodule

// File: rtl/led_fader.sv
// led_fader: LED breathing envelope. A four-state FSM ramps a duty value up,
// holds, ramps down, holds, advancing once per enabled tick; pwm_gen turns
// the duty into active-low PWM on the selected LEDs.
//   clk        - clock, all state on rising edge
//   rst_n      - asynchronous active-low reset
//   tick       - one-cycle envelope step strobe
//   enable     - 1 = fading and outputs active; 0 = frozen, LEDs off
//   pattern    - LED select, 1 = LED participates
//   led_output - registered active-low LED drive (0 = lit)
//   state_o    - current envelope state for debug
module led_fader
  import led_fader_pkg::*;
#(
  parameter int unsigned PWM_BITS   = DefPwmBits,
  parameter int unsigned STEP       = DefStep,
  parameter int unsigned HOLD_TICKS = DefHoldTicks
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                enable,
  input  logic [NumLeds-1:0]  pattern,
  output logic [NumLeds-1:0]  led_output,
  output logic [1:0]          state_o
);

  localparam logic [PWM_BITS-1:0] DutyMax    = '1;
  localparam logic [PWM_BITS:0]   DutyMaxExt = {1'b0, DutyMax};
  localparam logic [PWM_BITS:0]   StepExt    = (PWM_BITS + 1)'(STEP);
  localparam logic [PWM_BITS-1:0] StepN      = PWM_BITS'(STEP);

  localparam int unsigned HoldW       = (HOLD_TICKS > 2) ? $clog2(HOLD_TICKS) : 1;
  localparam int unsigned HoldLastInt = (HOLD_TICKS == 0) ? 0 : HOLD_TICKS - 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldLastInt);

  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [HoldW-1:0]    hold_q, hold_d;

  // One extra bit so duty+STEP cannot wrap before saturation.
  logic [PWM_BITS:0]   up_sum;
  logic                up_sat;
  logic                down_zero;

  assign up_sum    = {1'b0, duty_q} + StepExt;
  assign up_sat    = (up_sum >= DutyMaxExt);
  assign down_zero = ({1'b0, duty_q} <= StepExt);

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    hold_d  = hold_q;
    if (enable && tick) begin
      case (state_q)
        RampUp: begin
          if (up_sat) begin
            duty_d  = DutyMax;
            hold_d  = '0;
            state_d = (HOLD_TICKS == 0) ? RampDown : HoldHi;
          end else begin
            duty_d = up_sum[PWM_BITS-1:0];
          end
        end
        HoldHi: begin
          if (hold_q == HoldLast) begin
            hold_d  = '0;
            state_d = RampDown;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        RampDown: begin
          if (down_zero) begin
            duty_d  = '0;
            hold_d  = '0;
            state_d = (HOLD_TICKS == 0) ? RampUp : HoldLo;
          end else begin
            duty_d = duty_q - StepN;
          end
        end
        HoldLo: begin
          if (hold_q == HoldLast) begin
            hold_d  = '0;
            state_d = RampUp;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: state_d = RampUp;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RampUp;
      duty_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      hold_q  <= hold_d;
    end
  end

  assign state_o = state_q;

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable_i  (enable),
    .duty_i    (duty_q),
    .pattern_i (pattern),
    .led_o     (led_output)
  );

endmodule

// File: tb/tb_led_fader.sv
module tb_led_fader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic       enable = 1'b0;
  logic [5:0] pattern = 6'h00;
  logic [5:0] led5, led4;
  logic [1:0] st5, st4;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] duty;
  } exp_t;

  exp_t q5[$];
  exp_t q4[$];

  // Expected envelope after each of 12 ticks from reset (STEP=5 and STEP=4).
  logic [3:0] d5tab [12] = '{5, 10, 15, 15, 15, 10, 5, 0, 0, 0, 5, 10};
  logic [1:0] s5tab [12] = '{0, 0, 1, 1, 2, 2, 2, 3, 3, 0, 0, 0};
  logic [3:0] d4tab [12] = '{4, 8, 12, 15, 15, 15, 11, 7, 3, 0, 0, 0};
  logic [1:0] s4tab [12] = '{0, 0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 0};

  always #5 clk = ~clk;

  led_fader #(.PWM_BITS(4), .STEP(5), .HOLD_TICKS(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .enable     (enable),
    .pattern    (pattern),
    .led_output (led5),
    .state_o    (st5)
  );

  led_fader #(.PWM_BITS(4), .STEP(4), .HOLD_TICKS(2)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .enable     (enable),
    .pattern    (pattern),
    .led_output (led4),
    .state_o    (st4)
  );

  task automatic pulse_tick;
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
  endtask

  task automatic apply_reset;
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (led5 !== 6'h3F) begin failures++; $display("FAIL reset_led5: got %h expected 3f", led5); end
    checks++;
    if (led4 !== 6'h3F) begin failures++; $display("FAIL reset_led4: got %h expected 3f", led4); end
    checks++;
    if (st5 !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", st5); end
    checks++;
    if (dut.duty_q !== 4'd0) begin
      failures++; $display("FAIL reset_duty: got %0d expected 0", dut.duty_q);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_pwm_shape;
    int n;
    int odd;
    logic [4:0] want [3] = '{0, 10, 15};
    enable  = 1'b1;
    pattern = 6'h3F;
    for (int s = 0; s < 3; s++) begin
      if (s == 1) begin pulse_tick(); pulse_tick(); end
      if (s == 2) pulse_tick();
      repeat (40) @(posedge clk);
      n = 0;
      odd = 0;
      for (int c = 0; c < 16; c++) begin
        @(posedge clk); #1;
        if (led5[0] == 1'b0) n++;
        if (led5 !== 6'h00 && led5 !== 6'h3F) odd++;
      end
      checks++;
      if (n != int'(want[s])) begin
        failures++; $display("FAIL pwm_low_count: got %0d expected %0d", n, want[s]);
      end
      checks++;
      if (odd != 0) begin failures++; $display("FAIL pwm_leds_unequal: got %0d expected 0", odd); end
    end
  endtask

  task automatic test_envelope;
    exp_t e;
    apply_reset();
    enable  = 1'b1;
    pattern = 6'h3F;
    for (int i = 0; i < 12; i++) begin
      q5.push_back('{st: s5tab[i], duty: d5tab[i]});
      q4.push_back('{st: s4tab[i], duty: d4tab[i]});
      pulse_tick();
      e = q5.pop_front();
      checks++;
      if ({st5, dut.duty_q} !== e) begin
        failures++;
        $display("FAIL envelope_s5 tick %0d: got st=%0d duty=%0d expected st=%0d duty=%0d",
                 i + 1, st5, dut.duty_q, e.st, e.duty);
      end
      e = q4.pop_front();
      checks++;
      if ({st4, dut4.duty_q} !== e) begin
        failures++;
        $display("FAIL envelope_s4 tick %0d: got st=%0d duty=%0d expected st=%0d duty=%0d",
                 i + 1, st4, dut4.duty_q, e.st, e.duty);
      end
      repeat (3) @(posedge clk);
    end
  endtask

  task automatic test_enable_gating;
    exp_t e;
    int bad;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      checks++;
      if (led5 !== 6'h3F) begin failures++; $display("FAIL gated_led: got %h expected 3f", led5); end
    end
    checks++;
    if ({st5, dut.duty_q} !== {2'd0, 4'd10}) begin
      failures++; $display("FAIL gated_frozen_s5: got st=%0d duty=%0d expected st=0 duty=10",
                           st5, dut.duty_q);
    end
    checks++;
    if ({st4, dut4.duty_q} !== {2'd0, 4'd0}) begin
      failures++; $display("FAIL gated_frozen_s4: got st=%0d duty=%0d expected st=0 duty=0",
                           st4, dut4.duty_q);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (led5 !== 6'h3F) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL gated_dark: got %0d lit cycles expected 0", bad); end
    enable = 1'b1;
    q5.push_back('{st: 2'd1, duty: 4'd15});
    q4.push_back('{st: 2'd0, duty: 4'd4});
    pulse_tick();
    e = q5.pop_front();
    checks++;
    if ({st5, dut.duty_q} !== e) begin
      failures++; $display("FAIL resume_s5: got st=%0d duty=%0d expected st=%0d duty=%0d",
                           st5, dut.duty_q, e.st, e.duty);
    end
    e = q4.pop_front();
    checks++;
    if ({st4, dut4.duty_q} !== e) begin
      failures++; $display("FAIL resume_s4: got st=%0d duty=%0d expected st=%0d duty=%0d",
                           st4, dut4.duty_q, e.st, e.duty);
    end
  endtask

  task automatic test_boundary;
    exp_t e;
    logic prev;
    bit found;
    int bad, n0, n1;
    apply_reset();
    enable  = 1'b1;
    pattern = 6'h01;
    pulse_tick();
    repeat (40) @(posedge clk);
    #1;
    prev  = led5[0];
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clk); #1;
      if (prev == 1'b1 && led5[0] == 1'b0) found = 1'b1;
      prev = led5[0];
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL boundary_sync: got no led0 falling edge expected one");
    end else begin
      bad = 0;
      for (int k = 1; k <= 15; k++) begin
        @(posedge clk); #1;
        if (k == 15) tick = 1'b0;
        if (k >= 6 && led5 !== 6'h3F) bad++;
        if (k == 5) pattern = 6'h02;
        if (k == 14) begin
          tick = 1'b1;
          q5.push_back('{st: 2'd0, duty: 4'd10});
        end
      end
      e = q5.pop_front();
      checks++;
      if ({st5, dut.duty_q} !== e) begin
        failures++; $display("FAIL boundary_tick: got st=%0d duty=%0d expected st=%0d duty=%0d",
                             st5, dut.duty_q, e.st, e.duty);
      end
      checks++;
      if (bad != 0) begin
        failures++; $display("FAIL boundary_midperiod: got %0d changed cycles expected 0", bad);
      end
      n0 = 0;
      n1 = 0;
      for (int k = 16; k <= 31; k++) begin
        @(posedge clk); #1;
        if (led5[0] == 1'b0) n0++;
        if (led5[1] == 1'b0) n1++;
      end
      checks++;
      if (n0 != 0) begin failures++; $display("FAIL boundary_old_led: got %0d expected 0", n0); end
      checks++;
      if (n1 != 5) begin failures++; $display("FAIL boundary_pre_tick: got %0d expected 5", n1); end
      n1 = 0;
      for (int k = 32; k <= 47; k++) begin
        @(posedge clk); #1;
        if (led5[1] == 1'b0) n1++;
      end
      checks++;
      if (n1 != 10) begin failures++; $display("FAIL boundary_post_tick: got %0d expected 10", n1); end
    end
  endtask

  task automatic test_reset_mid_ramp;
    exp_t e;
    bit lit;
    lit = 1'b0;
    for (int c = 0; c < 40 && !lit; c++) begin
      @(posedge clk); #1;
      if (led5 !== 6'h3F) lit = 1'b1;
    end
    checks++;
    if (!lit) begin failures++; $display("FAIL midramp_lit: got dark expected lit led"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (led5 !== 6'h3F) begin failures++; $display("FAIL midramp_led: got %h expected 3f", led5); end
    checks++;
    if ({st5, dut.duty_q} !== 6'd0) begin
      failures++; $display("FAIL midramp_state: got st=%0d duty=%0d expected st=0 duty=0",
                           st5, dut.duty_q);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    q5.push_back('{st: 2'd0, duty: 4'd5});
    pulse_tick();
    e = q5.pop_front();
    checks++;
    if ({st5, dut.duty_q} !== e) begin
      failures++; $display("FAIL first_tick: got st=%0d duty=%0d expected st=%0d duty=%0d",
                           st5, dut.duty_q, e.st, e.duty);
    end
  endtask

  initial begin
    test_reset();
    test_pwm_shape();
    test_envelope();
    test_enable_gating();
    test_boundary();
    test_reset_mid_ramp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/led_fader.md
LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8: PWM counter and duty width; DUTY_MAX = 2^PWM_BITS-1.
REQ-002 SHALL have parameter STEP, default 8: duty increment/decrement per tick; legal range 1..DUTY_MAX.
REQ-003 SHALL have parameter HOLD_TICKS, default 4: ticks spent in each hold state; 0 = no hold.
REQ-004 SHALL have port clk, input, 1: single clock domain, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port tick, input, 1: one-cycle strobe from the upstream timer overflow; envelope step rate.
REQ-007 SHALL have port enable, input, 1: 1 = fading and outputs active; 0 = frozen, all LEDs off.
REQ-008 SHALL have port pattern, input, 6: LED select from the upstream LED counter, 1 = LED participates.
REQ-009 SHALL have port led_output, output, 6: registered, active-low LED drive (0 = lit).
REQ-010 SHALL have port state_o, output, 2: current envelope state, for debug.

Function
REQ-011 SHALL run pwm_cnt, PWM_BITS wide, incrementing every cycle and wrapping DUTY_MAX->0 regardless of enable.
REQ-012 SHALL define period boundary as the cycle where pwm_cnt == DUTY_MAX.
REQ-013 SHALL latch duty into active_duty and pattern into active_pat only at the period boundary; no mid-period change.
REQ-014 SHALL set led_output[i] = ~(enable & active_pat[i] & (pwm_cnt < active_duty)), registered, 1 cycle behind the compare.
REQ-015 SHALL accept active_duty = DUTY_MAX as lit DUTY_MAX of 2^PWM_BITS cycles and active_duty = 0 as never lit.
REQ-016 SHALL implement envelope FSM with states RAMP_UP, HOLD_HI, RAMP_DOWN, HOLD_LO; encoding 0..3 on state_o.
REQ-017 SHALL ignore tick when enable = 0; FSM, duty and hold_cnt hold their values.
REQ-018 In RAMP_UP on tick, SHALL set duty = min(duty+STEP, DUTY_MAX), computed with one extra bit to avoid overflow; if the result equals DUTY_MAX, SHALL go to HOLD_HI (or directly to RAMP_DOWN if HOLD_TICKS = 0) with hold_cnt = 0.
REQ-019 In HOLD_HI on tick, SHALL increment hold_cnt; on the tick where hold_cnt == HOLD_TICKS-1, SHALL go to RAMP_DOWN.
REQ-020 In RAMP_DOWN on tick, SHALL set duty = max(duty-STEP, 0) with no underflow wrap; if the result is 0, SHALL go to HOLD_LO (or RAMP_UP if HOLD_TICKS = 0) with hold_cnt = 0.
REQ-021 In HOLD_LO on tick, SHALL mirror REQ-019 and exit to RAMP_UP.
REQ-022 SHALL update duty and state the cycle after tick; that value reaches led_output at the next period boundary + 1 cycle.
REQ-023 SHALL handle tick coinciding with the period boundary by latching the pre-tick duty; the new duty takes effect one period later.
REQ-024 SHALL apply a pattern change in the next period only, with no glitch pulse on any LED.

Reset
REQ-025 On rst_n = 0, SHALL immediately set: pwm_cnt = 0, duty = 0, active_duty = 0, active_pat = 0, hold_cnt = 0, state = RAMP_UP, led_output = 6'b111111 (all off).
REQ-026 SHALL treat reset mid-ramp or mid-hold identically; no state is retained.
REQ-027 SHALL begin RAMP_UP on the first enabled tick after reset release.

Structure
REQ-028 SHALL place the state enum and default parameter constants in package led_fader_pkg.
REQ-029 SHALL isolate pwm_cnt, the boundary-latched duty/pattern and the compare in one sub-module, pwm_gen; the FSM stays in led_fader.

Verification
All scenarios use PWM_BITS=4, STEP=5, HOLD_TICKS=2 unless noted.
REQ-030 Reset: assert rst_n low mid-ramp -> led_output = 6'h3F the same cycle; state_o = 0 and duty = 0.
REQ-031 Full envelope: enable=1, pattern=6'h3F, 12 ticks -> duty sequence 5, 10, 15 (HOLD_HI), hold 2 ticks, then 10, 5, 0 (HOLD_LO), hold 2 ticks, back to RAMP_UP.
REQ-032 Saturation (STEP=4): duty 0, 4, 8, 12, 15 -> HOLD_HI; never 16 or 0 from wrap. RAMP_DOWN: 15, 11, 7, 3, 0.
REQ-033 PWM shape: active_duty = 10 -> each LED low exactly 10 of 16 cycles per period. active_duty = 0 -> never low. active_duty = 15 -> low 15 of 16 cycles.
REQ-034 Boundary: tick on a pwm_cnt = 15 cycle and pattern toggled mid-period -> no output change until the next boundary; no single-cycle glitch.
REQ-035 Enable gating: enable=0 with 3 ticks -> all LEDs high, duty and state unchanged; re-enable -> resumes from the frozen duty.
